mem_scrub_walker: RTL and testbench



---
 rtl/mem_scrub_pkg.sv | 26 ++
 rtl/mem_scrub_walker.sv | 152 +++++++++++++++
 tb/tb_mem_scrub_walker.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/mem_scrub_pkg.sv
// Shared types and the address-derived fill pattern for the memory scrub walker.
package mem_scrub_pkg;

  typedef enum logic [1:0] {
    ModeFill  = 2'd0,
    ModeCheck = 2'd1,
    ModeScrub = 2'd2
  } mode_t;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } state_t;

  // Park writes at DEPTH_MEM - PARK_OFFSET, the reserved scratch word.
  localparam int unsigned PARK_OFFSET = 1;
  localparam int unsigned PatMaxW     = 64;

  function automatic logic [PatMaxW-1:0] pat(input logic [PatMaxW-1:0] seed,
                                             input logic [31:0]         addr);
    return seed ^ PatMaxW'(addr);
  endfunction

endpackage

// File: rtl/mem_scrub_walker.sv
// Fills, checks or scrubs an attached write-every-cycle block RAM with pattern seed ^ addr,
// reporting a saturating mismatch count and the first failing word.
module mem_scrub_walker
  import mem_scrub_pkg::*;
#(
  parameter int unsigned WID_MEM   = 32,
  parameter int unsigned DEPTH_MEM = 2048,
  parameter int unsigned ERR_W     = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [1:0]         mode,
  input  logic [WID_MEM-1:0] seed,
  output logic [31:0]        raddr,
  output logic [31:0]        waddr,
  output logic [WID_MEM-1:0] din,
  input  logic [WID_MEM-1:0] dout,
  output logic               busy,
  output logic               done,
  output logic [ERR_W-1:0]   err_count,
  output logic               err_valid,
  output logic [31:0]        first_err_addr,
  output logic [WID_MEM-1:0] first_err_data
);

  localparam logic [31:0]      ParkAddr = 32'(DEPTH_MEM - PARK_OFFSET);
  localparam logic [31:0]      LastAddr = 32'(DEPTH_MEM - PARK_OFFSET - 1);
  localparam logic [ERR_W-1:0] ErrMax   = {ERR_W{1'b1}};

  function automatic logic [WID_MEM-1:0] pat_w(input logic [WID_MEM-1:0] s,
                                               input logic [31:0]        a);
    return WID_MEM'(pat(PatMaxW'(s), a));
  endfunction

  state_t             state_q;
  mode_t              mode_q;
  mode_t              cmd_mode;
  logic [WID_MEM-1:0] seed_q;
  logic [31:0]        cnt_q, cnt_nxt;
  logic [31:0]        raddr_q, waddr_q;
  logic [WID_MEM-1:0] din_q;
  logic               busy_q, done_q;
  logic [ERR_W-1:0]   err_count_q;
  logic               err_valid_q;
  logic [31:0]        first_err_addr_q;
  logic [WID_MEM-1:0] first_err_data_q;
  logic               cmp_valid_q;
  logic [31:0]        cmp_addr_q;
  logic [WID_MEM-1:0] cmp_pat_q;
  logic               miscompare;

  always_comb begin
    case (mode)
      2'd0:    cmd_mode = ModeFill;
      2'd2:    cmd_mode = ModeScrub;
      default: cmd_mode = ModeCheck;
    endcase
  end

  assign cnt_nxt    = cnt_q + 32'd1;
  // dout now holds the word read one cycle ago, aligned with the cmp_* stage.
  assign miscompare = cmp_valid_q && (dout != cmp_pat_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= StIdle;
      mode_q           <= ModeCheck;
      seed_q           <= '0;
      cnt_q            <= '0;
      raddr_q          <= '0;
      waddr_q          <= ParkAddr;
      din_q            <= '0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      err_count_q      <= '0;
      err_valid_q      <= 1'b0;
      first_err_addr_q <= '0;
      first_err_data_q <= '0;
      cmp_valid_q      <= 1'b0;
      cmp_addr_q       <= '0;
      cmp_pat_q        <= '0;
    end else begin
      done_q      <= 1'b0;
      cmp_valid_q <= 1'b0;
      if (miscompare) begin
        if (err_count_q != ErrMax) err_count_q <= err_count_q + 1'b1;
        if (!err_valid_q) begin
          err_valid_q      <= 1'b1;
          first_err_addr_q <= cmp_addr_q;
          first_err_data_q <= dout;
        end
      end
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q          <= StRun;
            mode_q           <= cmd_mode;
            seed_q           <= seed;
            busy_q           <= 1'b1;
            cnt_q            <= '0;
            raddr_q          <= '0;
            err_count_q      <= '0;
            err_valid_q      <= 1'b0;
            first_err_addr_q <= '0;
            first_err_data_q <= '0;
            if (cmd_mode != ModeCheck) begin
              waddr_q <= '0;
              din_q   <= pat_w(seed, 32'd0);
            end
          end
        end
        StRun: begin
          cmp_valid_q <= (mode_q != ModeFill);
          cmp_addr_q  <= cnt_q;
          cmp_pat_q   <= pat_w(seed_q, cnt_q);
          if (cnt_q == LastAddr) begin
            state_q <= StDrain;
            raddr_q <= '0;
            waddr_q <= ParkAddr;
            din_q   <= '0;
          end else begin
            cnt_q   <= cnt_nxt;
            raddr_q <= cnt_nxt;
            if (mode_q != ModeCheck) begin
              waddr_q <= cnt_nxt;
              din_q   <= pat_w(seed_q, cnt_nxt);
            end
          end
        end
        StDrain: begin
          state_q <= StDone;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign raddr          = raddr_q;
  assign waddr          = waddr_q;
  assign din            = din_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign err_count      = err_count_q;
  assign err_valid      = err_valid_q;
  assign first_err_addr = first_err_addr_q;
  assign first_err_data = first_err_data_q;

endmodule

// File: tb/tb_mem_scrub_walker.sv
// Directed bench: walker driving a small read-first, write-every-cycle RAM (DEPTH 16, N=15).
module tb_mem_scrub_walker;

  localparam int unsigned W = 32;
  localparam int unsigned D = 16;
  localparam int unsigned E = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic [W-1:0]  seed = '0;
  logic [31:0]   raddr, waddr;
  logic [W-1:0]  din;
  logic [W-1:0]  dout;
  logic          busy, done, err_valid;
  logic [E-1:0]  err_count;
  logic [31:0]   first_err_addr;
  logic [W-1:0]  first_err_data;

  logic [W-1:0]  ram [D];
  logic          corrupt_en = 1'b0;
  logic [3:0]    corrupt_addr = '0;
  logic [W-1:0]  corrupt_data = '0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Read-first RAM with a one-cycle registered read; the corrupt port stands in for a
  // hierarchical poke of a single word.
  always @(posedge clk) begin
    dout <= ram[raddr[3:0]];
    if (corrupt_en) ram[corrupt_addr] <= corrupt_data;
    else            ram[waddr[3:0]]   <= din;
  end

  mem_scrub_walker #(
    .WID_MEM   (W),
    .DEPTH_MEM (D),
    .ERR_W     (E)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .mode           (mode),
    .seed           (seed),
    .raddr          (raddr),
    .waddr          (waddr),
    .din            (din),
    .dout           (dout),
    .busy           (busy),
    .done           (done),
    .err_count      (err_count),
    .err_valid      (err_valid),
    .first_err_addr (first_err_addr),
    .first_err_data (first_err_data)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one command and follow it to completion; optionally pulse a stray FILL start.
  task automatic run_cmd(input logic [1:0] m, input logic [W-1:0] s, input int pulse_at,
                         input string tag);
    int done_cyc = -1;
    int busy_bad = 0;
    mode  = m;
    seed  = s;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      start = 1'b0;
      if (busy !== (c <= 16)) busy_bad++;
      if (done === 1'b1) begin
        done_cyc = c;
        break;
      end
      if (c == pulse_at) begin
        start = 1'b1;
        mode  = 2'd0;
        seed  = 32'h0;
      end
      step();
    end
    start = 1'b0;
    check({tag, " done_cycle"}, 64'(done_cyc), 64'd17);
    check({tag, " busy_window"}, 64'(busy_bad), 64'd0);
    step();
    check({tag, " done_pulse_width"}, {63'd0, done}, 64'd0);
  endtask

  task automatic corrupt(input logic [3:0] a, input logic [W-1:0] v);
    corrupt_addr = a;
    corrupt_data = v;
    corrupt_en   = 1'b1;
    step();
    corrupt_en   = 1'b0;
    step();
  endtask

  initial begin
    int ram_bad;
    step();
    step();
    check("rst busy", {63'd0, busy}, 64'd0);
    check("rst done", {63'd0, done}, 64'd0);
    check("rst err_count", 64'(err_count), 64'd0);
    check("rst err_valid", {63'd0, err_valid}, 64'd0);
    check("rst first_err_addr", 64'(first_err_addr), 64'd0);
    check("rst first_err_data", 64'(first_err_data), 64'd0);
    check("rst raddr", 64'(raddr), 64'd0);
    check("rst waddr", 64'(waddr), 64'd15);
    check("rst din", 64'(din), 64'd0);
    reset = 1'b0;
    step();

    // FILL then clean CHECK
    run_cmd(2'd0, 32'hA5A5_0000, 0, "fill");
    ram_bad = 0;
    for (int a = 0; a < 15; a++) if (ram[a] !== (32'hA5A5_0000 | a)) ram_bad++;
    check("fill contents", 64'(ram_bad), 64'd0);
    run_cmd(2'd1, 32'hA5A5_0000, 0, "check_clean");
    check("check_clean err_count", 64'(err_count), 64'd0);
    check("check_clean err_valid", {63'd0, err_valid}, 64'd0);

    // Single corrupted word
    corrupt(4'd5, 32'h0);
    run_cmd(2'd1, 32'hA5A5_0000, 0, "check_bad5");
    check("check_bad5 err_count", 64'(err_count), 64'd1);
    check("check_bad5 err_valid", {63'd0, err_valid}, 64'd1);
    check("check_bad5 first_err_addr", 64'(first_err_addr), 64'd5);
    check("check_bad5 first_err_data", 64'(first_err_data), 64'd0);

    // SCRUB repairs it
    run_cmd(2'd2, 32'hA5A5_0000, 0, "scrub");
    check("scrub err_count", 64'(err_count), 64'd1);
    check("scrub first_err_addr", 64'(first_err_addr), 64'd5);
    run_cmd(2'd1, 32'hA5A5_0000, 0, "check_after_scrub");
    check("check_after_scrub err_count", 64'(err_count), 64'd0);
    check("check_after_scrub err_valid", {63'd0, err_valid}, 64'd0);
    check("scrub ram5", 64'(ram[5]), 64'hA5A5_0005);

    // Wrong seed: every word mismatches, counter saturates
    run_cmd(2'd1, 32'h1, 0, "check_sat");
    check("check_sat err_count", 64'(err_count), 64'd7);
    check("check_sat err_valid", {63'd0, err_valid}, 64'd1);
    check("check_sat first_err_addr", 64'(first_err_addr), 64'd0);
    check("check_sat first_err_data", 64'(first_err_data), 64'hA5A5_0000);

    // Stray FILL start during RUN must be ignored
    run_cmd(2'd1, 32'h1, 5, "ignore_start");
    check("ignore_start err_count", 64'(err_count), 64'd7);
    check("ignore_start first_err_data", 64'(first_err_data), 64'hA5A5_0000);
    check("ignore_start ram3", 64'(ram[3]), 64'hA5A5_0003);
    check("ignore_start idle", {63'd0, busy}, 64'd0);

    // Reset in cycle 7 of a FILL
    mode  = 2'd0;
    seed  = 32'h1234_0000;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c < 7; c++) step();
    reset = 1'b1;
    step();
    check("rst_mid busy", {63'd0, busy}, 64'd0);
    check("rst_mid err_count", 64'(err_count), 64'd0);
    check("rst_mid waddr", 64'(waddr), 64'd15);
    check("rst_mid din", 64'(din), 64'd0);
    reset = 1'b0;
    step();
    ram_bad = 0;
    for (int a = 0; a < 6; a++) if (ram[a] !== (32'h1234_0000 | a)) ram_bad++;
    check("rst_mid written words", 64'(ram_bad), 64'd0);
    ram_bad = 0;
    for (int a = 7; a < 15; a++) if (ram[a] !== (32'hA5A5_0000 | a)) ram_bad++;
    check("rst_mid untouched words", 64'(ram_bad), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
